// File: rtl/fxp_mac_sched_pkg.sv
// Shared types for the fixed-point MAC scheduler: pipeline tag and saturation limits.
package FPU_p;

   localparam int ID_MAX_W = 8;

   typedef struct packed {
      logic [ID_MAX_W-1:0] id;
      logic                last;
      logic                valid;
   } tag_t;

   // Largest positive (neg=0) or most negative (neg=1) value of a w-bit signed word.
   function automatic logic signed [127:0] sat_limit(input int w, input logic neg);
      logic signed [127:0] one;
      one = 128'sd1;
      if (neg) return -(one <<< (w - 1));
      return (one <<< (w - 1)) - one;
   endfunction

endpackage

// File: rtl/fxp_mac_sched_arb.sv
// Round-robin arbiter: priority search starts at ptr, ptr moves past the winner on accept.
module rr_arbiter
   import FPU_p::*;
#(
   parameter  int N_REQ = 4,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [N_REQ-1:0] valid,
   input  logic             accept,
   output logic [N_REQ-1:0] grant,
   output logic [ID_W-1:0]  grant_id
);

   logic [ID_W-1:0] ptr;

   always_comb begin
      int   idx;
      logic found;
      grant    = '0;
      grant_id = '0;
      found    = 1'b0;
      idx      = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(ptr) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && valid[idx]) begin
            found       = 1'b1;
            grant[idx]  = 1'b1;
            grant_id    = ID_W'(idx);
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         ptr <= '0;
      end else if (accept) begin
         if (grant_id == ID_W'(N_REQ - 1)) ptr <= '0;
         else                              ptr <= grant_id + 1'b1;
      end
   end

endmodule

// File: rtl/fxp_mac_sched.sv
// Shared fixed-point MAC with round-robin requesters and per-requester accumulators.
// Define FXP_MAC_SAT_EN to saturate product truncation and accumulation instead of wrapping.
module fxp_mac_sched
   import FPU_p::*;
#(
   parameter  int N_REQ  = 4,
   parameter  int N_INT  = 8,
   parameter  int N_MANT = 23,
   parameter  int LAT    = 2,
   localparam int W      = N_INT + N_MANT + 1,
   localparam int ID_W   = $clog2(N_REQ)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  clear,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ-1:0]      req_last,
   input  logic signed [W-1:0]   req_a [N_REQ],
   input  logic signed [W-1:0]   req_b [N_REQ],
   output logic [N_REQ-1:0]      req_ready,
   output logic                  out_valid,
   output logic [ID_W-1:0]       out_id,
   output logic signed [W-1:0]   out_data,
   output logic                  busy
);

`ifdef FXP_MAC_SAT_EN
   localparam logic signed [2*W-1:0] PROD_MAX = (2*W)'(sat_limit(W, 1'b0));
   localparam logic signed [2*W-1:0] PROD_MIN = (2*W)'(sat_limit(W, 1'b1));

   function automatic logic signed [W-1:0] fit_prod(input logic signed [2*W-1:0] x);
      if (x > PROD_MAX) return W'(PROD_MAX);
      if (x < PROD_MIN) return W'(PROD_MIN);
      return W'(x);
   endfunction

   function automatic logic signed [W-1:0] acc_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      logic signed [W:0] s;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1]) return s[W] ? W'(PROD_MIN) : W'(PROD_MAX);
      return s[W-1:0];
   endfunction
`else
   function automatic logic signed [W-1:0] fit_prod(input logic signed [2*W-1:0] x);
      return W'(x);
   endfunction

   function automatic logic signed [W-1:0] acc_add(input logic signed [W-1:0] a,
                                                   input logic signed [W-1:0] b);
      return a + b;
   endfunction
`endif

   logic [N_REQ-1:0]      arb_valid;
   logic [N_REQ-1:0]      grant;
   logic [ID_W-1:0]       gnt_id;
   logic                  accept;
   logic signed [W-1:0]   a_sel;
   logic signed [W-1:0]   b_sel;
   logic signed [2*W-1:0] prod_full;
   logic signed [2*W-1:0] prod_shift;
   logic signed [W-1:0]   prod_fit;

   tag_t                  tag_p  [LAT];
   logic signed [W-1:0]   prod_p [LAT];
   logic signed [W-1:0]   acc    [N_REQ];

   tag_t                  fin;
   logic [ID_W-1:0]       fin_id;
   logic signed [W-1:0]   fin_sum;
   logic                  fin_out;
   logic                  unused_tag;

   // Clear blocks every grant in its cycle, so no term is accepted while flushing.
   assign arb_valid = clear ? '0 : req_valid;

   rr_arbiter #(.N_REQ(N_REQ)) u_arb (
      .clk      (clk),
      .rstn     (rstn),
      .valid    (arb_valid),
      .accept   (accept),
      .grant    (grant),
      .grant_id (gnt_id)
   );

   assign req_ready = rstn ? grant : '0;
   assign accept    = |req_ready;

   assign a_sel      = req_a[gnt_id];
   assign b_sel      = req_b[gnt_id];
   assign prod_full  = (2*W)'(a_sel) * (2*W)'(b_sel);
   assign prod_shift = prod_full >>> N_MANT;
   assign prod_fit   = fit_prod(prod_shift);

   // Stage p0 captures the accepted term; later stages are a plain delay line.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < LAT; i++) tag_p[i] <= '0;
      end else begin
         tag_p[0] <= '{id: ID_MAX_W'(gnt_id), last: req_last[gnt_id], valid: accept};
         for (int i = 1; i < LAT; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      prod_p[0] <= prod_fit;
      for (int i = 1; i < LAT; i++) prod_p[i] <= prod_p[i-1];
   end

   always_comb begin
      busy = 1'b0;
      for (int i = 0; i < LAT; i++) busy = busy | tag_p[i].valid;
   end

   // Final stage: accumulate into the owning requester and emit on last.
   assign fin        = tag_p[LAT-1];
   assign fin_id     = fin.id[ID_W-1:0];
   assign unused_tag = ^fin.id;
   assign fin_sum    = acc_add(acc[fin_id], prod_p[LAT-1]);
   assign fin_out    = fin.valid & fin.last & ~clear;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         for (int r = 0; r < N_REQ; r++) acc[r] <= '0;
      end else if (clear) begin
         for (int r = 0; r < N_REQ; r++) acc[r] <= '0;
      end else if (fin.valid) begin
         acc[fin_id] <= fin.last ? '0 : fin_sum;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid <= 1'b0;
         out_id    <= '0;
         out_data  <= '0;
      end else begin
         out_valid <= fin_out;
         if (fin_out) begin
            out_id   <= fin_id;
            out_data <= fin_sum;
         end
      end
   end

endmodule

// File: tb/tb_fxp_mac_sched.sv
// Self-checking bench for fxp_mac_sched (Q3.4, LAT=2, 4 requesters) against a queue-based model.
module tb_fxp_mac_sched;

   localparam int N   = 4;
   localparam int NI  = 3;
   localparam int NM  = 4;
   localparam int LAT = 2;
   localparam int W   = NI + NM + 1;

   logic                clk = 1'b0;
   logic                rstn;
   logic                clear;
   logic [N-1:0]        req_valid;
   logic [N-1:0]        req_last;
   logic signed [W-1:0] req_a [N];
   logic signed [W-1:0] req_b [N];
   logic [N-1:0]        req_ready;
   logic                out_valid;
   logic [1:0]          out_id;
   logic signed [W-1:0] out_data;
   logic                busy;

   always #5 clk = ~clk;

   fxp_mac_sched #(.N_REQ(N), .N_INT(NI), .N_MANT(NM), .LAT(LAT)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .clear     (clear),
      .req_valid (req_valid),
      .req_last  (req_last),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_ready (req_ready),
      .out_valid (out_valid),
      .out_id    (out_id),
      .out_data  (out_data),
      .busy      (busy)
   );

   typedef struct { int a; int b; bit last; } term_t;
   typedef struct { int id; bit last; int prod; int due; } pend_t;

   term_t tq [N][$];
   pend_t pq [$];
   int    acc_m [N];
   int    last_g, ecnt, exp_id, exp_data;
   bit    exp_ov;
   int    checks, errors;
   int    glog [$];
   int    gcyc [$];
   int    oid_q [$];
   int    odat_q [$];
   int    ocyc_q [$];

   function automatic int fit(int v);
`ifdef FXP_MAC_SAT_EN
      if (v > 127) return 127;
      if (v < -128) return -128;
      return v;
`else
      int m;
      m = v & 255;
      return (m > 127) ? m - 256 : m;
`endif
   endfunction

   function automatic int mulq(int a, int b);
      return fit((a * b) >>> NM);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < N; r++) acc_m[r] = 0;
      pq.delete();
      last_g   = N - 1;
      exp_ov   = 1'b0;
      exp_id   = 0;
      exp_data = 0;
   endtask

   function automatic int tq_total();
      int t;
      t = 0;
      for (int r = 0; r < N; r++) t += tq[r].size();
      return t;
   endfunction

   function automatic void clr_logs();
      glog.delete(); gcyc.delete(); oid_q.delete(); odat_q.delete(); ocyc_q.delete();
   endfunction

   task automatic step(input bit clr);
      int    gid, idx, s;
      pend_t p;
      term_t t;
      for (int r = 0; r < N; r++) begin
         if (tq[r].size() > 0) begin
            req_valid[r] = 1'b1;
            req_a[r]     = W'(tq[r][0].a);
            req_b[r]     = W'(tq[r][0].b);
            req_last[r]  = tq[r][0].last;
         end else begin
            req_valid[r] = 1'b0;
            req_a[r]     = W'($urandom);
            req_b[r]     = W'($urandom);
            req_last[r]  = 1'($urandom);
         end
      end
      clear = clr;
      #1;
      gid = -1;
      if (!clr)
         for (int k = 1; k <= N; k++) begin
            idx = (last_g + k) % N;
            if (gid < 0 && tq[idx].size() > 0) gid = idx;
         end
      chk("ready", 32'(req_ready), (gid < 0) ? 0 : (1 << gid));
      @(posedge clk);
      ecnt++;
      exp_ov = 1'b0;
      if (clr) begin
         for (int r = 0; r < N; r++) acc_m[r] = 0;
         pq.delete();
      end else begin
         if (pq.size() > 0 && pq[0].due == ecnt) begin
            p = pq.pop_front();
            s = fit(acc_m[p.id] + p.prod);
            if (p.last) begin
               exp_ov = 1'b1; exp_id = p.id; exp_data = s; acc_m[p.id] = 0;
            end else begin
               acc_m[p.id] = s;
            end
         end
         if (gid >= 0) begin
            t = tq[gid].pop_front();
            pq.push_back('{gid, t.last, mulq(t.a, t.b), ecnt + LAT});
            last_g = gid;
            glog.push_back(gid);
            gcyc.push_back(ecnt);
         end
      end
      @(negedge clk);
      chk("out_valid", 32'(out_valid), 32'(exp_ov));
      chk("out_id", 32'(out_id), exp_id);
      chk("out_data", out_data, exp_data);
      chk("busy", 32'(busy), 32'(pq.size() != 0));
      if (out_valid === 1'b1) begin
         oid_q.push_back(int'(out_id));
         odat_q.push_back(int'(out_data));
         ocyc_q.push_back(ecnt);
      end
   endtask

   task automatic run_all(input int maxc);
      int n;
      n = 0;
      while ((tq_total() > 0 || pq.size() > 0) && n < maxc) begin
         step(1'b0);
         n++;
      end
      if (n >= maxc) chk("timeout", tq_total() + pq.size(), 0);
   endtask

   task automatic run_feed(input int maxc);
      int n;
      n = 0;
      while (tq_total() > 0 && n < maxc) begin
         step(1'b0);
         n++;
      end
      if (n >= maxc) chk("feed_timeout", tq_total(), 0);
   endtask

   initial begin
      int ovf_exp;
      checks = 0; errors = 0; ecnt = 0;
      rstn = 1'b0; clear = 1'b0; req_valid = '0; req_last = '0;
      for (int r = 0; r < N; r++) begin req_a[r] = '0; req_b[r] = '0; end
      model_reset();
      repeat (3) @(negedge clk);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_id", 32'(out_id), 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_busy", 32'(busy), 0);
      rstn = 1'b1;

      // Basic dot product: 2.0*1.5 + 1.0*1.0 = 4.0
      clr_logs();
      tq[0].push_back('{32, 24, 1'b0});
      tq[0].push_back('{16, 16, 1'b1});
      run_all(20);
      chk("basic_cnt", oid_q.size(), 1);
      chk("basic_id", oid_q[0], 0);
      chk("basic_data", odat_q[0], 64);
      chk("basic_lat", ocyc_q[0] - gcyc[gcyc.size()-1], LAT);

      // Fairness: every requester always valid
      clr_logs();
      for (int r = 0; r < N; r++)
         for (int k = 0; k < 3; k++) tq[r].push_back('{16, 16 + k, 1'b1});
      run_all(40);
      chk("fair_cnt", glog.size(), 12);
      for (int i = 1; i < glog.size(); i++) begin
         chk("fair_seq", glog[i], (glog[i-1] + 1) % N);
         chk("fair_cyc", gcyc[i] - gcyc[i-1], 1);
      end

      // Interleaving: req 2 completes inside req 1's dot product
      clr_logs();
      tq[1].push_back('{16, 16, 1'b0});
      run_feed(10);
      tq[2].push_back('{32, 16, 1'b1});
      run_feed(10);
      tq[1].push_back('{16, 16, 1'b1});
      run_all(20);
      chk("ilv_cnt", oid_q.size(), 2);
      chk("ilv_id0", oid_q[0], 2);
      chk("ilv_d0", odat_q[0], 32);
      chk("ilv_id1", oid_q[1], 1);
      chk("ilv_d1", odat_q[1], 32);

      // Overflow of the product truncation
      clr_logs();
`ifdef FXP_MAC_SAT_EN
      ovf_exp = 127;
`else
      ovf_exp = -16;
`endif
      tq[3].push_back('{127, 127, 1'b1});
      run_all(20);
      chk("ovf_cnt", oid_q.size(), 1);
      chk("ovf_data", odat_q[0], ovf_exp);

      // Clear one cycle after a last-term transfer
      clr_logs();
      tq[0].push_back('{16, 16, 1'b1});
      run_feed(10);
      step(1'b1);
      chk("clr_busy", 32'(busy), 0);
      repeat (4) step(1'b0);
      chk("clr_noout", oid_q.size(), 0);
      tq[0].push_back('{16, 16, 1'b1});
      run_all(20);
      chk("clr_after_cnt", oid_q.size(), 1);
      chk("clr_after_data", odat_q[0], 16);

      // Randomized traffic with occasional clears
      clr_logs();
      for (int c = 0; c < 400; c++) begin
         for (int r = 0; r < N; r++)
            if (tq[r].size() == 0 && $urandom_range(0, 1) == 1)
               tq[r].push_back('{int'($urandom_range(0, 255)) - 128,
                                 int'($urandom_range(0, 255)) - 128,
                                 $urandom_range(0, 3) == 0});
         step($urandom_range(0, 39) == 0);
      end
      run_all(100);

      // Asynchronous reset with the pipeline full
      for (int r = 0; r < N; r++) tq[r].push_back('{16, 16, 1'b1});
      step(1'b0);
      step(1'b0);
      chk("pre_rst_busy", 32'(busy), 1);
      #3 rstn = 1'b0;
      #1;
      chk("arst_out_valid", 32'(out_valid), 0);
      chk("arst_out_id", 32'(out_id), 0);
      chk("arst_out_data", out_data, 0);
      chk("arst_busy", 32'(busy), 0);
      chk("arst_ready", 32'(req_ready), 0);
      model_reset();
      for (int r = 0; r < N; r++) begin
         tq[r].delete();
         tq[r].push_back('{16, 8 * (r + 1), 1'b1});
      end
      @(negedge clk);
      rstn = 1'b1;
      clr_logs();
      step(1'b0);
      chk("rst_first_grant", glog[0], 0);
      run_all(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
